// File: rtl/register_file_param_if.sv
// Bus bundle for register_file_param: decode-side read/reserve signals and
// writeback-side write signals. The master drives addresses, data and strobes;
// the slave (the register file) returns read data and busy flags.
interface register_file_param_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic                  writeEnable;
   logic [ADDR_W-1:0]     rD_address;
   logic [DATA_W-1:0]     rD_data;
   logic [DATA_W/8-1:0]   byte_en;
   logic [ADDR_W-1:0]     rA_address;
   logic [ADDR_W-1:0]     rB_address;
   logic [DATA_W-1:0]     rA_data;
   logic [DATA_W-1:0]     rB_data;
   logic                  reserve_en;
   logic [ADDR_W-1:0]     reserve_address;
   logic                  rA_busy;
   logic                  rB_busy;

   modport master (
      output writeEnable, rD_address, rD_data, byte_en,
      output rA_address, rB_address, reserve_en, reserve_address,
      input  rA_data, rB_data, rA_busy, rB_busy
   );

   modport slave (
      input  writeEnable, rD_address, rD_data, byte_en,
      input  rA_address, rB_address, reserve_en, reserve_address,
      output rA_data, rB_data, rA_busy, rB_busy
   );
endinterface

// File: rtl/register_file_param.sv
// register_file_param: DEPTH x DATA_W register file, two combinational read
// ports, one byte-masked write port, and a per-register busy scoreboard used
// by decode for RAW hazard detection.
// Optional feature macro RF_BYPASS_EN: when defined, a read of the register
// being written in the same cycle returns the merged (post-write) value and
// its busy flag reflects the post-edge state.
module register_file_param #(
   parameter int DATA_W   = 64,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input logic                    clk,
   input logic                    reset,
   register_file_param_if.slave   bus
);
   localparam int LANES = DATA_W / 8;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;

   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];
   logic              rd_busy [2];

   // Replace the enabled byte lanes of old_val with those of new_val.
   function automatic logic [DATA_W-1:0] lane_merge(
      input logic [DATA_W-1:0] old_val,
      input logic [DATA_W-1:0] new_val,
      input logic [LANES-1:0]  be
   );
      logic [DATA_W-1:0] res;
      res = old_val;
      for (int i = 0; i < LANES; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_val[8*i +: 8];
         end
      end
      return res;
   endfunction

   // True for an address that maps onto real, writable storage: in range and
   // not the hardwired zero register.
   function automatic logic addr_live(input logic [ADDR_W-1:0] a);
      logic ok;
      ok = ({1'b0, a} < (ADDR_W+1)'(DEPTH));
      if ((ZERO_REG != 0) && (a == '0)) begin
         ok = 1'b0;
      end else begin
         ok = ok;
      end
      return ok;
   endfunction

   assign rd_addr[0] = bus.rA_address;
   assign rd_addr[1] = bus.rB_address;

   // Register storage: byte-masked writeback, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.writeEnable && addr_live(bus.rD_address)) begin
         regs[bus.rD_address] <= lane_merge(regs[bus.rD_address], bus.rD_data, bus.byte_en);
      end
   end

   // Busy scoreboard: writeback releases, reserve sets; the later set wins a same-address tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= '0;
      end else begin
         if (bus.writeEnable && addr_live(bus.rD_address)) begin
            busy[bus.rD_address] <= 1'b0;
         end
         if (bus.reserve_en && addr_live(bus.reserve_address)) begin
            busy[bus.reserve_address] <= 1'b1;
         end
      end
   end

   // Read ports: stored data and busy, forced to zero under reset, for the zero register and out of range.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = '0;
         rd_busy[p] = 1'b0;
         if (reset) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
         end else if (addr_live(rd_addr[p])) begin
            rd_data[p] = regs[rd_addr[p]];
            rd_busy[p] = busy[rd_addr[p]];
`ifdef RF_BYPASS_EN
            if (bus.writeEnable && (rd_addr[p] == bus.rD_address)) begin
               rd_data[p] = lane_merge(regs[rd_addr[p]], bus.rD_data, bus.byte_en);
               rd_busy[p] = bus.reserve_en && (bus.reserve_address == rd_addr[p]);
            end else begin
               rd_data[p] = regs[rd_addr[p]];
            end
`endif
         end else begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
         end
      end
   end

   assign bus.rA_data = rd_data[0];
   assign bus.rB_data = rd_data[1];
   assign bus.rA_busy = rd_busy[0];
   assign bus.rB_busy = rd_busy[1];
endmodule
